// File: rtl/soc_bus_arbiter_pkg.sv
// Shared encodings for the SoC peripheral bus arbiter: FSM states, master ids, counter width.
package soc_bus_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;
  localparam int   CNT_W = 4;
endpackage

// File: rtl/soc_bus_arbiter_if.sv
// Master-side request/ack signals and decoder-side bus signals of the peripheral bus arbiter.
interface soc_bus_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          m0_req, m0_we, m0_ack;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m1_req, m1_we, m1_ack;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [DW-1:0] m_rdata;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          busy;

  // slave: the arbiter itself; master: masters plus decoder/read-mux environment
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, bus_rdata,
    output m0_ack, m1_ack, m_rdata, bus_we, bus_addr, bus_wdata, busy
  );
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, bus_rdata,
    input  m0_ack, m1_ack, m_rdata, bus_we, bus_addr, bus_wdata, busy
  );
endinterface

// File: rtl/soc_bus_arbiter_rr_arb2.sv
// Combinational 2-way round-robin: on contention the master that did not own the bus last wins.
module soc_bus_arbiter_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       grant_id,
  output logic       grant_valid
);
  always_comb begin
    grant_valid = |req;
    grant_id    = (req == 2'b11) ? ~last_owner : req[1];
  end
endmodule

// File: rtl/soc_bus_arbiter.sv
// Two-master peripheral bus arbiter: latches one transaction, holds it WAIT_CYCLES, single-cycle WE, one-cycle ack.
module soc_bus_arbiter
  import soc_bus_arbiter_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int WAIT_CYCLES = 2
) (
  input logic               clk,
  input logic               rst,
  soc_bus_arbiter_if.slave  bif
);
  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_owner_q, last_owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic               gnt_id, gnt_valid;

  soc_bus_arbiter_rr_arb2 u_rr (
    .req         ({bif.m1_req, bif.m0_req}),
    .last_owner  (last_owner_q),
    .grant_id    (gnt_id),
    .grant_valid (gnt_valid)
  );

  // last_owner resets to DMA so the CPU wins the first contention
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= M_CPU;
      last_owner_q <= M_DMA;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    case (state_q)
      ST_IDLE: if (gnt_valid) begin
        state_d = ST_ACCESS;
        owner_d = gnt_id;
        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
        we_d    = (gnt_id == M_DMA) ? bif.m1_we    : bif.m0_we;
        addr_d  = (gnt_id == M_DMA) ? bif.m1_addr  : bif.m0_addr;
        wdata_d = (gnt_id == M_DMA) ? bif.m1_wdata : bif.m0_wdata;
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d      = ST_DONE;
          last_owner_d = owner_q;
          if (!we_q) rdata_d = bif.bus_rdata;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bif.bus_we = (state_q == ST_ACCESS) && (cnt_q == '0) && we_q;
    bif.m0_ack = (state_q == ST_DONE) && (owner_q == M_CPU);
    bif.m1_ack = (state_q == ST_DONE) && (owner_q == M_DMA);
    bif.busy   = (state_q != ST_IDLE);
  end

  assign bif.bus_addr  = addr_q;
  assign bif.bus_wdata = wdata_q;
  assign bif.m_rdata   = rdata_q;
endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Directed bench for soc_bus_arbiter with a small dmem/fact slave model behind the bus.
module tb_soc_bus_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int W  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   we_pulses = 0, we_long = 0, ack0_n = 0, ack1_n = 0;
  logic we_prev = 1'b0;
  logic [31:0] dmem [0:63] = '{4: 32'hDEADBEEF, default: 32'h0};
  logic [31:0] fact_in = 32'h0;
  int   id, n, save_we, save_a0, save_a1;

  soc_bus_arbiter_if #(.DW(DW), .AW(AW)) bif ();

  soc_bus_arbiter #(.DW(DW), .AW(AW), .WAIT_CYCLES(W)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  always #5 clk = ~clk;

  // read mux: page 0 = dmem, 0x804 = fact input register
  always_comb begin
    bif.bus_rdata = 32'h0;
    if (bif.bus_addr[11:8] == 4'h0)
      bif.bus_rdata = dmem[bif.bus_addr[7:2]];
    else if (bif.bus_addr[11:0] == 12'h804)
      bif.bus_rdata = fact_in;
  end

  always @(posedge clk) begin
    if (bif.bus_we) begin
      we_pulses <= we_pulses + 1;
      if (bif.bus_addr[11:8] == 4'h0) dmem[bif.bus_addr[7:2]] <= bif.bus_wdata;
      else if (bif.bus_addr[11:0] == 12'h804) fact_in <= bif.bus_wdata;
    end
    if (bif.bus_we && we_prev) we_long <= we_long + 1;
    we_prev <= bif.bus_we;
    if (bif.m0_ack) ack0_n <= ack0_n + 1;
    if (bif.m1_ack) ack1_n <= ack1_n + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(output int aid, output int cyc);
    aid = -1;
    cyc = 0;
    while (aid < 0 && cyc < 20) begin
      tick();
      cyc++;
      if (bif.m0_ack) aid = 0;
      else if (bif.m1_ack) aid = 1;
    end
    if (aid < 0) begin
      tests++;
      fails++;
      $error("FAIL ack_timeout: got no ack expected ack within 20 cycles");
    end else begin
      chk("ack_exclusive", 32'(bif.m0_ack & bif.m1_ack), 32'h0);
    end
  endtask

  task automatic set_m0(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
    bif.m0_req = r; bif.m0_we = we; bif.m0_addr = a; bif.m0_wdata = d;
  endtask

  task automatic set_m1(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
    bif.m1_req = r; bif.m1_we = we; bif.m1_addr = a; bif.m1_wdata = d;
  endtask

  initial begin
    set_m0(0, 0, 0, 0);
    set_m1(0, 0, 0, 0);
    repeat (2) tick();
    chk("rst_busy",   32'(bif.busy),   32'h0);
    chk("rst_we",     32'(bif.bus_we), 32'h0);
    chk("rst_addr",   bif.bus_addr,    32'h0);
    chk("rst_wdata",  bif.bus_wdata,   32'h0);
    chk("rst_rdata",  bif.m_rdata,     32'h0);
    chk("rst_ack0",   32'(bif.m0_ack), 32'h0);
    chk("rst_ack1",   32'(bif.m1_ack), 32'h0);
    rst = 1'b0;
    tick();

    // single write to fact input register
    set_m0(1, 1, 32'h0000_0804, 32'h5);
    tick();
    chk("wr_busy",  32'(bif.busy),   32'h1);
    chk("wr_addr",  bif.bus_addr,    32'h804);
    chk("wr_wdata", bif.bus_wdata,   32'h5);
    chk("wr_we_c1", 32'(bif.bus_we), 32'h0);
    tick();
    chk("wr_we_c2", 32'(bif.bus_we), 32'h1);
    tick();
    chk("wr_ack0",  32'(bif.m0_ack), 32'h1);
    chk("wr_ack1",  32'(bif.m1_ack), 32'h0);
    chk("wr_we_dn", 32'(bif.bus_we), 32'h0);
    set_m0(0, 0, 0, 0);
    tick();
    chk("wr_ack_off", 32'(bif.m0_ack), 32'h0);
    chk("wr_idle",    32'(bif.busy),   32'h0);
    chk("wr_fact",    fact_in,         32'h5);
    chk("wr_pulses",  32'(we_pulses),  32'h1);
    chk("wr_we_len",  32'(we_long),    32'h0);

    // single read by m1 from dmem
    set_m1(1, 0, 32'h10, 32'h0);
    wait_ack(id, n);
    chk("rd_id",      32'(id),          32'h1);
    chk("rd_latency", 32'(n),           32'h3);
    chk("rd_data",    bif.m_rdata,      32'hDEADBEEF);
    chk("rd_ack0",    32'(bif.m0_ack),  32'h0);
    set_m1(0, 0, 0, 0);
    tick();
    chk("rd_ack_off", 32'(bif.m1_ack),  32'h0);

    // reset while a write is in ACCESS
    set_m0(1, 1, 32'h0000_0804, 32'h7);
    tick();
    save_we = we_pulses;
    save_a0 = ack0_n;
    rst = 1'b1;
    #1;
    chk("mid_busy",  32'(bif.busy),   32'h0);
    chk("mid_we",    32'(bif.bus_we), 32'h0);
    chk("mid_addr",  bif.bus_addr,    32'h0);
    chk("mid_wdata", bif.bus_wdata,   32'h0);
    chk("mid_rdata", bif.m_rdata,     32'h0);
    set_m0(0, 0, 0, 0);
    repeat (3) tick();
    chk("mid_pulses", 32'(we_pulses), 32'(save_we));
    chk("mid_acks",   32'(ack0_n),    32'(save_a0));
    chk("mid_fact",   fact_in,        32'h5);

    // contention from reset: strict alternation starting with m0
    set_m0(1, 0, 32'h10, 32'h0);
    set_m1(1, 0, 32'h10, 32'h0);
    save_a0 = ack0_n;
    save_a1 = ack1_n;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_ack(id, n);
      chk("rr_order",   32'(id), 32'(i % 2));
      chk("rr_spacing", 32'(n),  (i == 0) ? 32'h3 : 32'h4);
    end
    chk("rr_rdata", bif.m_rdata, 32'hDEADBEEF);
    set_m0(0, 0, 0, 0);
    set_m1(0, 0, 0, 0);
    repeat (2) tick();
    chk("rr_idle", 32'(bif.busy),        32'h0);
    chk("rr_m0n",  32'(ack0_n - save_a0), 32'h4);
    chk("rr_m1n",  32'(ack1_n - save_a1), 32'h4);

    // late arrival: m1 joins during m0 ACCESS and is served before m0's repeat
    save_we = we_pulses;
    set_m0(1, 1, 32'h20, 32'h11);
    tick();
    set_m1(1, 0, 32'h20, 32'h0);
    wait_ack(id, n);
    chk("late_first",  32'(id), 32'h0);
    chk("late_n1",     32'(n),  32'h2);
    wait_ack(id, n);
    chk("late_second", 32'(id), 32'h1);
    chk("late_n2",     32'(n),  32'h4);
    chk("late_rdata",  bif.m_rdata, 32'h11);
    set_m1(0, 0, 0, 0);
    wait_ack(id, n);
    chk("late_third",  32'(id), 32'h0);
    chk("late_n3",     32'(n),  32'h4);
    set_m0(0, 0, 0, 0);
    tick();
    chk("late_pulses", 32'(we_pulses - save_we), 32'h2);

    // payload change during ACCESS is ignored
    set_m0(1, 0, 32'h10, 32'h0);
    tick();
    bif.m0_addr = 32'h20;
    chk("pay_addr_c1", bif.bus_addr, 32'h10);
    tick();
    chk("pay_addr_c2", bif.bus_addr, 32'h10);
    tick();
    chk("pay_ack",     32'(bif.m0_ack), 32'h1);
    chk("pay_addr_dn", bif.bus_addr,    32'h10);
    chk("pay_rdata",   bif.m_rdata,     32'hDEADBEEF);
    set_m0(0, 0, 0, 0);
    tick();
    chk("pay_idle", 32'(bif.busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
